decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered, parametrised RV32I(+M) decode pipeline stage between fetch and execute.
//  Accepts {pc, IR} over a valid/ready handshake and decodes it into the existing control bundle
//  (ALU op, imm, format, WB/DM controls, rd), plus rs1/rs2, illegal/ecall/ebreak flags.
//  A BUF_DEPTH-entry FIFO of decoded entries decouples fetch from execute stalls; flush supports redirects.
// PARAMETERS
//  XLEN       32  datapath/PC width; only 32 is supported.
//  BUF_DEPTH  2   decoded-entry FIFO depth; power of 2, >= 2.
//  ENABLE_M   1   1: decode RV32M (funct7=0000001 on OP_FUNC2); 0: those encodings flag illegal.
// PORTS
//  clk              in   1     clock, rising edge
//  rst_n            in   1     asynchronous reset, active low
//  flush            in   1     drop all buffered entries and any input this cycle
//  in_valid         in   1     fetch presents pc/IR
//  in_ready         out  1     stage can accept; = (count < BUF_DEPTH); never depends on out_ready
//  in_pc            in   XLEN  instruction address
//  in_ir            in   32    instruction word
//  out_valid        out  1     head entry valid
//  out_ready        in   1     execute consumes head
//  out_pc           out  XLEN  pc of head entry
//  alu_instruction  out  5     ALU op code (`I* constants, incl. new M ops)
//  immediate_value  out  32    sign/format-extended immediate
//  instruction_format_type out 3  `FT_*
//  write_back_type  out  2     `WB_*
//  data_memory_read_status / data_memory_write_status  out 2 each  `DM_*
//  data_memory_load_signed, pc_for_input_a, jump  out 1 each
//  destination_register_number out 5; rs1_number, rs2_number out 5 each
//  illegal, ecall, ebreak  out 1 each
// BEHAVIOUR
//  - Reset (async, rst_n=0): count=0, head/tail ptr=0, out_valid=0, in_ready=1; all decoded outputs 0
//    (fields = zero-value encodings). Reset mid-operation discards all entries.
//  - Push when in_valid&&in_ready&&!flush; pop when out_valid&&out_ready&&!flush. Both in one cycle: count unchanged.
//  - Latency: entry accepted at edge N is on outputs with out_valid=1 after edge N (empty FIFO). No bypass.
//  - Outputs come from FIFO head; stable while out_valid&&!out_ready. Order strictly FIFO.
//  - Full: in_ready=0 even if out_ready=1 that cycle (no same-cycle push-on-pop at full).
//  - Flush: at next edge count=0, ptrs=0, out_valid=0; input ignored that cycle; flush beats push/pop.
//  - Pointers wrap modulo BUF_DEPTH; count width clog2(BUF_DEPTH)+1.
//  - Decode per opcode: LUI/AUIPC/JAL/JALR/BR/LOAD/STORE/FUNC1/FUNC2 per existing encoding;
//    FT_S/FT_B force rd=0; FENCE: legal, rd=0, no side effects.
//  - illegal=1 for: IR[1:0]!=2'b11; unknown opcode; BR f3 010/011; LOAD f3 011/110/111; STORE f3>=011;
//    SLLI/SRLI/SRAI or R-type with undefined funct7; M encodings when ENABLE_M=0;
//    SYSTEM other than ecall (0x00000073) / ebreak (0x00100073). Illegal entries: rd=0, jump=0,
//    DM statuses `DM_NONE, alu=`IADD; still pass through FIFO in order.
//  - ENABLE_M=1, funct7=0000001: f3 000..111 -> IMUL,IMULH,IMULHSU,IMULHU,IDIV,IDIVU,IREM,IREMU.
//  - ecall/ebreak: exactly one flag set, rd=0, illegal=0.
//  - rs1_number=IR[19:15], rs2_number=IR[24:20] always (consumer qualifies by format).
// STRUCTURE
//  - format.vh: add IMUL..IREMU ALU codes (5-bit space) and `OP_SYSTEM alias; no new FT/WB/DM codes.
//  - Sub-module decode_core: purely combinational IR -> control bundle + illegal/ecall/ebreak,
//    parametrised by ENABLE_M; decode_stage instantiates it on in_ir and stores its result in the FIFO.
//  - FIFO storage: BUF_DEPTH x {pc, bundle} register array, head/tail ptrs, count.
// TESTING
//  - addi x1,x0,5 (0x00500093) -> next cycle out_valid=1, IADD, imm=5, FT_I, rd=1, illegal=0.
//  - sub x3,x1,x2 (0x402081B3) -> ISUB, FT_R, rd=3, rs1=1, rs2=2.
//  - beq x0,x0,-4 (0xFE000EE3) -> IEQ, imm=0xFFFFFFFC, jump=1, rd=0.
//  - mul x5,x6,x7 (0x027302B3): ENABLE_M=1 -> IMUL rd=5; ENABLE_M=0 -> illegal=1, rd=0.
//  - BUF_DEPTH=2, out_ready=0, push 3 -> in_ready=0 after 2; release -> pcs drain in order, third then accepted.
//  - Buffer full + flush (and separately rst_n low mid-stream) -> next edge out_valid=0, in_ready=1, nothing emitted.

Source files
------------

// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : decode_stage_pkg
//  Purpose : Shared encodings for the RV32I(+M) decode stage. Contains the
//            opcode map, the 5-bit ALU operation space (including the M ops),
//            the instruction-format, write-back and data-memory codes, and
//            the packed control bundle produced by decode.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package decode_stage_pkg;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FUNC1  = 7'b0010011;
    localparam logic [6:0] OP_FUNC2  = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU operations; the M block occupies 16..23 so IMUL + funct3 selects it
    localparam logic [4:0] IADD    = 5'd0;
    localparam logic [4:0] ISUB    = 5'd1;
    localparam logic [4:0] ISLL    = 5'd2;
    localparam logic [4:0] ISLT    = 5'd3;
    localparam logic [4:0] ISLTU   = 5'd4;
    localparam logic [4:0] IXOR    = 5'd5;
    localparam logic [4:0] ISRL    = 5'd6;
    localparam logic [4:0] ISRA    = 5'd7;
    localparam logic [4:0] IOR     = 5'd8;
    localparam logic [4:0] IAND    = 5'd9;
    localparam logic [4:0] IEQ     = 5'd10;
    localparam logic [4:0] INE     = 5'd11;
    localparam logic [4:0] ILT     = 5'd12;
    localparam logic [4:0] IGE     = 5'd13;
    localparam logic [4:0] ILTU    = 5'd14;
    localparam logic [4:0] IGEU    = 5'd15;
    localparam logic [4:0] IMUL    = 5'd16;
    localparam logic [4:0] IMULH   = 5'd17;
    localparam logic [4:0] IMULHSU = 5'd18;
    localparam logic [4:0] IMULHU  = 5'd19;
    localparam logic [4:0] IDIV    = 5'd20;
    localparam logic [4:0] IDIVU   = 5'd21;
    localparam logic [4:0] IREM    = 5'd22;
    localparam logic [4:0] IREMU   = 5'd23;

    // Instruction formats
    localparam logic [2:0] FT_NONE = 3'd0;
    localparam logic [2:0] FT_R    = 3'd1;
    localparam logic [2:0] FT_I    = 3'd2;
    localparam logic [2:0] FT_S    = 3'd3;
    localparam logic [2:0] FT_B    = 3'd4;
    localparam logic [2:0] FT_U    = 3'd5;
    localparam logic [2:0] FT_J    = 3'd6;

    // Write-back source
    localparam logic [1:0] WB_NONE = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_MEM  = 2'd2;
    localparam logic [1:0] WB_PC4  = 2'd3;

    // Data-memory access width
    localparam logic [1:0] DM_NONE = 2'd0;
    localparam logic [1:0] DM_BYTE = 2'd1;
    localparam logic [1:0] DM_HALF = 2'd2;
    localparam logic [1:0] DM_WORD = 2'd3;

    // Decoded control bundle; all-zero is the idle/reset encoding
    typedef struct packed {
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [1:0]  wb;
        logic [1:0]  dm_rd;
        logic [1:0]  dm_wr;
        logic        ld_signed;
        logic        pc_a;
        logic        jump;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
        logic        ecall;
        logic        ebreak;
    } decode_t;

endpackage : decode_stage_pkg
`default_nettype wire

// File: rtl/decode_stage_core.sv
`default_nettype none
// ============================================================================
//  Module  : decode_core
//  Purpose : Purely combinational RV32I(+M) instruction decoder. Maps an
//            instruction word onto the control bundle and raises
//            illegal/ecall/ebreak. Illegal words collapse to the idle bundle
//            (only rs1/rs2 and the illegal flag survive).
//  Ports   : i_ir   in  32  instruction word
//            o_dec  out     decoded control bundle (decode_t)
//  Rev     : 1.0  initial release
// ============================================================================
module decode_core
    import decode_stage_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [31:0] i_ir,
    output decode_t     o_dec
);

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [4:0]  w_alu_f3;
    decode_t     w_dec;
    logic        w_bad;

    assign w_op = i_ir[6:0];
    assign w_f3 = i_ir[14:12];
    assign w_f7 = i_ir[31:25];

    assign w_imm_i = {{20{i_ir[31]}}, i_ir[31:20]};
    assign w_imm_s = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
    assign w_imm_b = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
    assign w_imm_u = {i_ir[31:12], 12'b0};
    assign w_imm_j = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};

    // Base ALU op for funct3 on OP-IMM / OP (funct7 variants patched below)
    always_comb begin
        w_alu_f3 = IADD;
        case (w_f3)
            3'b000: w_alu_f3 = IADD;
            3'b001: w_alu_f3 = ISLL;
            3'b010: w_alu_f3 = ISLT;
            3'b011: w_alu_f3 = ISLTU;
            3'b100: w_alu_f3 = IXOR;
            3'b101: w_alu_f3 = ISRL;
            3'b110: w_alu_f3 = IOR;
            default: w_alu_f3 = IAND;
        endcase
    end

    always_comb begin
        w_dec     = '0;
        w_bad     = 1'b0;
        w_dec.rd  = i_ir[11:7];
        case (w_op)
            OP_LUI: begin
                w_dec.fmt = FT_U; w_dec.imm = w_imm_u; w_dec.wb = WB_ALU;
            end
            OP_AUIPC: begin
                w_dec.fmt = FT_U; w_dec.imm = w_imm_u; w_dec.wb = WB_ALU;
                w_dec.pc_a = 1'b1;
            end
            OP_JAL: begin
                w_dec.fmt = FT_J; w_dec.imm = w_imm_j; w_dec.wb = WB_PC4;
                w_dec.pc_a = 1'b1; w_dec.jump = 1'b1;
            end
            OP_JALR: begin
                w_dec.fmt = FT_I; w_dec.imm = w_imm_i; w_dec.wb = WB_PC4;
                w_dec.jump = 1'b1;
            end
            OP_BR: begin
                w_dec.fmt = FT_B; w_dec.imm = w_imm_b; w_dec.jump = 1'b1;
                case (w_f3)
                    3'b000:  w_dec.alu = IEQ;
                    3'b001:  w_dec.alu = INE;
                    3'b100:  w_dec.alu = ILT;
                    3'b101:  w_dec.alu = IGE;
                    3'b110:  w_dec.alu = ILTU;
                    3'b111:  w_dec.alu = IGEU;
                    default: w_bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_dec.fmt = FT_I; w_dec.imm = w_imm_i; w_dec.wb = WB_MEM;
                // funct3[1:0] is the width, funct3[2] selects zero-extension
                w_dec.dm_rd     = w_f3[1:0] + 2'd1;
                w_dec.ld_signed = ~w_f3[2];
                if (w_f3[1:0] == 2'b11 || w_f3 == 3'b110) begin
                    w_bad = 1'b1;
                end
            end
            OP_STORE: begin
                w_dec.fmt = FT_S; w_dec.imm = w_imm_s;
                w_dec.dm_wr = w_f3[1:0] + 2'd1;
                if (w_f3 >= 3'b011) begin
                    w_bad = 1'b1;
                end
            end
            OP_FUNC1: begin
                w_dec.fmt = FT_I; w_dec.imm = w_imm_i; w_dec.wb = WB_ALU;
                w_dec.alu = w_alu_f3;
                if (w_f3 == 3'b001 && w_f7 != 7'b0000000) begin
                    w_bad = 1'b1;
                end else if (w_f3 == 3'b101) begin
                    if (w_f7 == 7'b0100000) begin
                        w_dec.alu = ISRA;
                    end else if (w_f7 != 7'b0000000) begin
                        w_bad = 1'b1;
                    end
                end
            end
            OP_FUNC2: begin
                w_dec.fmt = FT_R; w_dec.wb = WB_ALU;
                if (w_f7 == 7'b0000000) begin
                    w_dec.alu = w_alu_f3;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_dec.alu = ISUB;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_dec.alu = ISRA;
                end else if (w_f7 == 7'b0000001 && ENABLE_M != 0) begin
                    w_dec.alu = IMUL | {2'b00, w_f3};
                end else begin
                    w_bad = 1'b1;
                end
            end
            OP_FENCE: begin
                w_dec.rd = 5'd0;
            end
            OP_SYSTEM: begin
                w_dec.rd = 5'd0;
                if (i_ir == 32'h0000_0073) begin
                    w_dec.ecall = 1'b1;
                end else if (i_ir == 32'h0010_0073) begin
                    w_dec.ebreak = 1'b1;
                end else begin
                    w_bad = 1'b1;
                end
            end
            default: w_bad = 1'b1;
        endcase

        // S/B formats have no destination
        if (w_dec.fmt == FT_S || w_dec.fmt == FT_B) begin
            w_dec.rd = 5'd0;
        end
        if (i_ir[1:0] != 2'b11) begin
            w_bad = 1'b1;
        end
        if (w_bad) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
        w_dec.rs1 = i_ir[19:15];
        w_dec.rs2 = i_ir[24:20];
    end

    assign o_dec = w_dec;

endmodule : decode_core
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module  : decode_stage
//  Purpose : Registered decode pipeline stage. Fetch hands over {pc, IR} on a
//            valid/ready handshake; the word is decoded immediately and the
//            result stored in a BUF_DEPTH-entry FIFO that feeds execute.
//            Flush empties the FIFO and ignores the input that cycle.
//  Ports   : clk, rst_n (async, active low), flush
//            in_valid/in_ready/in_pc/in_ir            fetch side
//            out_valid/out_ready/out_pc + bundle      execute side
//  Rev     : 1.0  initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2,
    parameter int ENABLE_M  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_ir,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      alu_instruction,
    output logic [31:0]     immediate_value,
    output logic [2:0]      instruction_format_type,
    output logic [1:0]      write_back_type,
    output logic [1:0]      data_memory_read_status,
    output logic [1:0]      data_memory_write_status,
    output logic            data_memory_load_signed,
    output logic            pc_for_input_a,
    output logic            jump,
    output logic [4:0]      destination_register_number,
    output logic [4:0]      rs1_number,
    output logic [4:0]      rs2_number,
    output logic            illegal,
    output logic            ecall,
    output logic            ebreak
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        decode_t         dec;
    } entry_t;

    decode_t          w_dec;
    entry_t           r_mem [BUF_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    entry_t           w_out;

    decode_core #(
        .ENABLE_M (ENABLE_M)
    ) u_core (
        .i_ir  (in_ir),
        .o_dec (w_dec)
    );

    // in_ready is a function of occupancy only, so a full buffer never
    // accepts even when execute drains the head that same cycle.
    assign in_ready  = (r_count < CNT_W'(BUF_DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{pc: in_pc, dec: w_dec};
        end
    end

    assign w_out = out_valid ? r_mem[r_head] : '0;

    assign out_pc                      = w_out.pc;
    assign alu_instruction             = w_out.dec.alu;
    assign immediate_value             = w_out.dec.imm;
    assign instruction_format_type     = w_out.dec.fmt;
    assign write_back_type             = w_out.dec.wb;
    assign data_memory_read_status     = w_out.dec.dm_rd;
    assign data_memory_write_status    = w_out.dec.dm_wr;
    assign data_memory_load_signed     = w_out.dec.ld_signed;
    assign pc_for_input_a              = w_out.dec.pc_a;
    assign jump                        = w_out.dec.jump;
    assign destination_register_number = w_out.dec.rd;
    assign rs1_number                  = w_out.dec.rs1;
    assign rs2_number                  = w_out.dec.rs2;
    assign illegal                     = w_out.dec.illegal;
    assign ecall                       = w_out.dec.ecall;
    assign ebreak                      = w_out.dec.ebreak;

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_decode_stage
//  Purpose : Self-checking bench for decode_stage. Two instances (M enabled
//            and disabled) receive identical stimulus; a queue-based FIFO
//            model and an arithmetic decode model provide expected values.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_ir;

    logic        m_in_ready, m_out_valid, n_in_ready, n_out_valid;
    logic [31:0] m_out_pc, n_out_pc;
    decode_t     m_dec, n_dec;

    int    n_tests = 0;
    int    n_fail  = 0;
    item_t q[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .BUF_DEPTH(DEPTH), .ENABLE_M(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_pc(in_pc), .in_ir(in_ir),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_out_pc),
        .alu_instruction(m_dec.alu), .immediate_value(m_dec.imm),
        .instruction_format_type(m_dec.fmt), .write_back_type(m_dec.wb),
        .data_memory_read_status(m_dec.dm_rd), .data_memory_write_status(m_dec.dm_wr),
        .data_memory_load_signed(m_dec.ld_signed), .pc_for_input_a(m_dec.pc_a),
        .jump(m_dec.jump), .destination_register_number(m_dec.rd),
        .rs1_number(m_dec.rs1), .rs2_number(m_dec.rs2),
        .illegal(m_dec.illegal), .ecall(m_dec.ecall), .ebreak(m_dec.ebreak)
    );

    decode_stage #(.XLEN(32), .BUF_DEPTH(DEPTH), .ENABLE_M(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_pc(in_pc), .in_ir(in_ir),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
        .alu_instruction(n_dec.alu), .immediate_value(n_dec.imm),
        .instruction_format_type(n_dec.fmt), .write_back_type(n_dec.wb),
        .data_memory_read_status(n_dec.dm_rd), .data_memory_write_status(n_dec.dm_wr),
        .data_memory_load_signed(n_dec.ld_signed), .pc_for_input_a(n_dec.pc_a),
        .jump(n_dec.jump), .destination_register_number(n_dec.rd),
        .rs1_number(n_dec.rs1), .rs2_number(n_dec.rs2),
        .illegal(n_dec.illegal), .ecall(n_dec.ecall), .ebreak(n_dec.ebreak)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decoder: immediates built by weighted sums of IR fields,
    // operations looked up from funct3 tables.
    function automatic decode_t model_decode(input logic [31:0] ir, input bit en_m);
        decode_t    d;
        bit         bad;
        logic [4:0] alu_tab [8] = '{IADD, ISLL, ISLT, ISLTU, IXOR, ISRL, IOR, IAND};
        logic [4:0] br_tab  [8] = '{IEQ, INE, IADD, IADD, ILT, IGE, ILTU, IGEU};
        int         f3, f7;
        logic [31:0] sx11, sx12, sx20, imm_i;
        f3    = int'(ir[14:12]);
        f7    = int'(ir[31:25]);
        sx11  = ir[31] ? 32'hFFFF_F800 : 32'h0;
        sx12  = ir[31] ? 32'hFFFF_F000 : 32'h0;
        sx20  = ir[31] ? 32'hFFF0_0000 : 32'h0;
        imm_i = sx11 + 32'(ir[30:20]);
        d     = '0;
        bad   = 1'b0;
        d.rd  = ir[11:7];
        if (ir[1:0] != 2'b11) bad = 1'b1;
        else if (ir[6:0] == OP_LUI || ir[6:0] == OP_AUIPC) begin
            d.fmt = FT_U; d.wb = WB_ALU; d.imm = 32'(ir[31:12]) * 4096;
            d.pc_a = (ir[6:0] == OP_AUIPC);
        end else if (ir[6:0] == OP_JAL) begin
            d.fmt = FT_J; d.wb = WB_PC4; d.jump = 1'b1; d.pc_a = 1'b1;
            d.imm = sx20 + 32'(ir[19:12]) * 4096 + 32'(ir[20]) * 2048 + 32'(ir[30:21]) * 2;
        end else if (ir[6:0] == OP_JALR) begin
            d.fmt = FT_I; d.wb = WB_PC4; d.jump = 1'b1; d.imm = imm_i;
        end else if (ir[6:0] == OP_BR) begin
            d.fmt = FT_B; d.jump = 1'b1; d.rd = 0; d.alu = br_tab[f3];
            d.imm = sx12 + 32'(ir[7]) * 2048 + 32'(ir[30:25]) * 32 + 32'(ir[11:8]) * 2;
            bad = (f3 == 2 || f3 == 3);
        end else if (ir[6:0] == OP_LOAD) begin
            d.fmt = FT_I; d.wb = WB_MEM; d.imm = imm_i;
            d.dm_rd = (f3 % 4 == 0) ? DM_BYTE : (f3 % 4 == 1) ? DM_HALF : DM_WORD;
            d.ld_signed = (f3 < 4);
            bad = (f3 == 3 || f3 >= 6);
        end else if (ir[6:0] == OP_STORE) begin
            d.fmt = FT_S; d.rd = 0;
            d.imm = sx11 + 32'(ir[30:25]) * 32 + 32'(ir[11:7]);
            d.dm_wr = (f3 == 0) ? DM_BYTE : (f3 == 1) ? DM_HALF : DM_WORD;
            bad = (f3 >= 3);
        end else if (ir[6:0] == OP_FUNC1) begin
            d.fmt = FT_I; d.wb = WB_ALU; d.imm = imm_i; d.alu = alu_tab[f3];
            if (f3 == 1 && f7 != 0) bad = 1'b1;
            if (f3 == 5 && f7 == 32) d.alu = ISRA;
            else if (f3 == 5 && f7 != 0) bad = 1'b1;
        end else if (ir[6:0] == OP_FUNC2) begin
            d.fmt = FT_R; d.wb = WB_ALU;
            if (f7 == 0) d.alu = alu_tab[f3];
            else if (f7 == 32 && f3 == 0) d.alu = ISUB;
            else if (f7 == 32 && f3 == 5) d.alu = ISRA;
            else if (f7 == 1 && en_m) d.alu = 5'(int'(IMUL) + f3);
            else bad = 1'b1;
        end else if (ir[6:0] == OP_FENCE) begin
            d.rd = 0;
        end else if (ir == 32'h0000_0073) begin
            d.rd = 0; d.ecall = 1'b1;
        end else if (ir == 32'h0010_0073) begin
            d.rd = 0; d.ebreak = 1'b1;
        end else bad = 1'b1;
        if (bad) begin
            d = '0;
            d.illegal = 1'b1;
        end
        d.rs1 = ir[19:15];
        d.rs2 = ir[24:20];
        return d;
    endfunction

    task automatic cmp_dec(input string p, input decode_t o, input decode_t e);
        chk({p, ".alu"}, 64'(o.alu), 64'(e.alu));
        chk({p, ".imm"}, 64'(o.imm), 64'(e.imm));
        chk({p, ".fmt"}, 64'(o.fmt), 64'(e.fmt));
        chk({p, ".wb"}, 64'(o.wb), 64'(e.wb));
        chk({p, ".dm"}, 64'({o.dm_rd, o.dm_wr, o.ld_signed}), 64'({e.dm_rd, e.dm_wr, e.ld_signed}));
        chk({p, ".pca_jump"}, 64'({o.pc_a, o.jump}), 64'({e.pc_a, e.jump}));
        chk({p, ".regs"}, 64'({o.rd, o.rs1, o.rs2}), 64'({e.rd, e.rs1, e.rs2}));
        chk({p, ".flags"}, 64'({o.illegal, o.ecall, o.ebreak}), 64'({e.illegal, e.ecall, e.ebreak}));
    endtask

    task automatic check_all();
        decode_t     em, en;
        logic [31:0] epc;
        logic        exp_ready, exp_valid;
        exp_ready = (q.size() < DEPTH);
        exp_valid = (q.size() != 0);
        chk("m.in_ready", 64'(m_in_ready), 64'(exp_ready));
        chk("n.in_ready", 64'(n_in_ready), 64'(exp_ready));
        chk("m.out_valid", 64'(m_out_valid), 64'(exp_valid));
        chk("n.out_valid", 64'(n_out_valid), 64'(exp_valid));
        em = '0; en = '0; epc = '0;
        if (exp_valid) begin
            em  = model_decode(q[0].ir, 1'b1);
            en  = model_decode(q[0].ir, 1'b0);
            epc = q[0].pc;
        end
        chk("m.out_pc", 64'(m_out_pc), 64'(epc));
        chk("n.out_pc", 64'(n_out_pc), 64'(epc));
        cmp_dec("m", m_dec, em);
        cmp_dec("n", n_dec, en);
    endtask

    // One clock: decide the handshake from model state, advance, then check.
    task automatic cycle();
        bit push, pop;
        push = in_valid && (q.size() < DEPTH) && !flush;
        pop  = (q.size() != 0) && out_ready && !flush;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back('{pc: in_pc, ir: in_ir});
        end
        #1;
        check_all();
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] ir);
        in_valid = 1'b1; in_pc = pc; in_ir = ir; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        out_ready = 1'b0;
    endtask

    logic [6:0] ops [11] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD,
                             OP_STORE, OP_FUNC1, OP_FUNC2, OP_FENCE, OP_SYSTEM};
    logic [6:0] f7s [3]  = '{7'h00, 7'h20, 7'h01};

    initial begin
        logic [31:0] rir;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_ir = '0;
        #12;
        check_all();
        chk("reset.in_ready", 64'(m_in_ready), 64'd1);
        chk("reset.out_valid", 64'(m_out_valid), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // addi x1,x0,5
        push_one(32'h100, 32'h0050_0093);
        chk("addi.valid", 64'(m_out_valid), 64'd1);
        chk("addi.alu", 64'(m_dec.alu), 64'(IADD));
        chk("addi.imm", 64'(m_dec.imm), 64'd5);
        chk("addi.fmt", 64'(m_dec.fmt), 64'(FT_I));
        chk("addi.rd", 64'(m_dec.rd), 64'd1);
        chk("addi.illegal", 64'(m_dec.illegal), 64'd0);
        drain();

        // sub x3,x1,x2
        push_one(32'h104, 32'h4020_81B3);
        chk("sub.alu", 64'(m_dec.alu), 64'(ISUB));
        chk("sub.fmt", 64'(m_dec.fmt), 64'(FT_R));
        chk("sub.regs", 64'({m_dec.rd, m_dec.rs1, m_dec.rs2}), 64'({5'd3, 5'd1, 5'd2}));
        drain();

        // beq x0,x0,-4
        push_one(32'h108, 32'hFE00_0EE3);
        chk("beq.alu", 64'(m_dec.alu), 64'(IEQ));
        chk("beq.imm", 64'(m_dec.imm), 64'hFFFF_FFFC);
        chk("beq.jump", 64'(m_dec.jump), 64'd1);
        chk("beq.rd", 64'(m_dec.rd), 64'd0);
        drain();

        // mul x5,x6,x7
        push_one(32'h10C, 32'h0273_02B3);
        chk("mul.m.alu", 64'(m_dec.alu), 64'(IMUL));
        chk("mul.m.rd", 64'(m_dec.rd), 64'd5);
        chk("mul.n.illegal", 64'(n_dec.illegal), 64'd1);
        chk("mul.n.rd", 64'(n_dec.rd), 64'd0);
        drain();

        // Fill to full with execute stalled, then release
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h200 + 32'(i * 4); in_ir = 32'h0000_0013;
            if (i < 2) cycle();
        end
        chk("full.in_ready", 64'(m_in_ready), 64'd0);
        cycle();
        chk("full.hold_pc", 64'(m_out_pc), 64'h200);
        out_ready = 1'b1;
        cycle();
        chk("full.no_push_on_pop", 64'(m_in_ready), 64'd1);
        chk("drain.pc1", 64'(m_out_pc), 64'h204);
        cycle();
        chk("drain.pc2", 64'(m_out_pc), 64'h208);
        in_valid = 1'b0;
        cycle();
        chk("drain.empty", 64'(m_out_valid), 64'd0);

        // Flush while full with input offered
        out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h0010_0073;
        cycle(); cycle();
        flush = 1'b1; out_ready = 1'b1;
        cycle();
        chk("flush.out_valid", 64'(m_out_valid), 64'd0);
        chk("flush.in_ready", 64'(m_in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        cycle();

        // Asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h0000_0073;
        cycle(); cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("rst.out_valid", 64'(m_out_valid), 64'd0);
        chk("rst.in_ready", 64'(m_in_ready), 64'd1);
        check_all();
        @(negedge clk); rst_n = 1'b1;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rir = $urandom;
            if ($urandom_range(0, 9) < 8) begin
                rir[6:0] = ops[$urandom_range(0, 10)];
                if ($urandom_range(0, 2) != 0) rir[31:25] = f7s[$urandom_range(0, 2)];
            end else if ($urandom_range(0, 1) == 1) begin
                rir = $urandom_range(0, 1) ? 32'h0000_0073 : 32'h0010_0073;
            end
            in_ir     = rir;
            in_pc     = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_decode_stage
`default_nettype wire
